// File: rtl/run_ctrl.sv
// run_ctrl: launch/run/done sequencer for a small program-driven engine.
// The bench raises start, and the program launches when start falls.
// The engine runs until the decoder reports a halt, then ack is raised.
// ack stays high until the next start request.
module run_ctrl #(
  parameter int              PC_W    = 10,
  parameter int              CNT_W   = 16,
  parameter logic [PC_W-1:0] P1_ADDR = PC_W'(32'd0),
  parameter logic [PC_W-1:0] P2_ADDR = PC_W'(32'd128),
  parameter logic [PC_W-1:0] P3_ADDR = PC_W'(32'd256)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  output logic             load_pc,
  output logic [PC_W-1:0]  start_addr,
  output logic             run_en,
  output logic             ack,
  output logic [1:0]       prog_sel,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_r;
  logic [2:0]       next_state_s;
  logic             load_pc_r;
  logic             run_en_r;
  logic             ack_r;
  logic [1:0]       prog_sel_r;
  logic [CNT_W-1:0] cycle_count_r;
  logic [PC_W-1:0]  start_addr_s;
  logic             cnt_sat_s;

  // Next-state decode. A launch waits in ARMED until start is released.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state_s = ST_ARMED;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_ARMED: begin
        if (start) begin
          next_state_s = ST_ARMED;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_LOAD: begin
        next_state_s = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Map the program index to its start address. Index 3 is unused and falls back to program 1.
  always_comb begin
    start_addr_s = P1_ADDR;
    case (prog_sel_r)
      2'd0:    start_addr_s = P1_ADDR;
      2'd1:    start_addr_s = P2_ADDR;
      2'd2:    start_addr_s = P3_ADDR;
      default: start_addr_s = P1_ADDR;
    endcase
  end

  assign cnt_sat_s = (cycle_count_r == CNT_MAX);

  // State register, plus the strobes registered from the next state so each one is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      load_pc_r <= 1'b0;
      run_en_r  <= 1'b0;
      ack_r     <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      load_pc_r <= (next_state_s == ST_LOAD);
      run_en_r  <= (next_state_s == ST_RUN);
      ack_r     <= (next_state_s == ST_DONE);
    end
  end

  // Program index: moves to the next program when a run halts, and wraps after program 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_sel_r <= 2'd0;
    end else if ((state_r == ST_RUN) && halt) begin
      prog_sel_r <= (prog_sel_r == 2'd2) ? 2'd0 : (prog_sel_r + 2'd1);
    end else begin
      prog_sel_r <= prog_sel_r;
    end
  end

  // Run-cycle counter: cleared on entry to LOAD, saturating count while in RUN, frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ARMED) && !start) begin
      cycle_count_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_RUN) && !cnt_sat_s) begin
      cycle_count_r <= cycle_count_r + CNT_ONE;
    end else begin
      cycle_count_r <= cycle_count_r;
    end
  end

  assign load_pc     = load_pc_r;
  assign run_en      = run_en_r;
  assign ack         = ack_r;
  assign prog_sel    = prog_sel_r;
  assign cycle_count = cycle_count_r;
  assign start_addr  = start_addr_s;

endmodule
